multiplier_unit: RTL



---
 rtl/multiplier_unit_pkg.sv | 67 ++++++
 rtl/multiplier_unit_datapath.sv | 118 +++++++++++
 rtl/multiplier_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/multiplier_unit_pkg.sv
// Shared types and helpers for the M-extension multiplier.
// The funct3 encoding is the one the divider uses as well.
package multiplier_unit_pkg;

    // RV32M funct3 encoding shared by the multiplier and the divider.
    // Multiply ops have funct3[2] == 0, divide/remainder ops have funct3[2] == 1.
    typedef enum logic [2:0] {
        FUNCT3_MUL    = 3'b000,
        FUNCT3_MULH   = 3'b001,
        FUNCT3_MULHSU = 3'b010,
        FUNCT3_MULHU  = 3'b011,
        FUNCT3_DIV    = 3'b100,
        FUNCT3_DIVU   = 3'b101,
        FUNCT3_REM    = 3'b110,
        FUNCT3_REMU   = 3'b111
    } mult_funct3_t;

    // Multiplier control states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mul_state_t;

    // One shift-add iteration per multiplier bit.
    localparam int unsigned MUL_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

    // Multiply class is every funct3 with the top bit clear.
    function automatic logic is_mul_op(input mult_funct3_t f);
        return (f[2] == 1'b0);
    endfunction

    // Magnitude of a 32-bit operand. 0x80000000 maps to itself, which is
    // exactly right when the magnitude is then used as an unsigned value.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic as_signed);
        logic [31:0] m;
        if (as_signed && v[31]) begin
            m = ~v + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Restores the sign of an unsigned 64-bit magnitude product.
    function automatic logic [63:0] sign_fix64(input logic [63:0] p, input logic neg);
        logic [63:0] r;
        if (neg) begin
            r = ~p + 64'd1;
        end else begin
            r = p;
        end
        return r;
    endfunction

    // rs1 is interpreted as signed for MULH and MULHSU.
    function automatic logic rs1_is_signed(input mult_funct3_t f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU);
    endfunction

    // rs2 is interpreted as signed for MULH only.
    function automatic logic rs2_is_signed(input mult_funct3_t f);
        return (f == FUNCT3_MULH);
    endfunction

endpackage

// File: rtl/multiplier_unit_datapath.sv
// Multiplier datapath: operand magnitude/sign latch, 64-bit shift-add
// product register, iteration counter and the sign-fix / half-select
// result register. Sequencing comes from the FSM in multiplier_unit.
module multiplier_datapath
    import multiplier_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,          // latch operands, clear product/counter
    input  mult_funct3_t op_in,
    input  logic [31:0]  rs1,
    input  logic [31:0]  rs2,
    input  logic         step,          // perform one shift-add iteration
    input  logic         res_final,     // register the signed result of this step
    input  logic         res_zero,      // register a zero result (bypass path)
    output logic         operand_zero,  // either incoming magnitude is zero
    output logic         last_iter,     // current iteration is the final one
    output logic [31:0]  result
);

    logic [31:0]      mcand_q, mcand_d;
    logic             neg_q, neg_d;
    mult_funct3_t     op_q, op_d;
    logic [63:0]      product_q, product_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      result_q, result_d;

    logic [31:0]      rs1_mag_s;
    logic [31:0]      rs2_mag_s;
    logic             rs1_neg_s;
    logic             rs2_neg_s;
    logic [32:0]      hi_sum_s;
    logic [63:0]      fixed_s;

    // Operand magnitudes and signs as seen on the request inputs.
    always_comb begin
        rs1_neg_s    = rs1_is_signed(op_in) & rs1[31];
        rs2_neg_s    = rs2_is_signed(op_in) & rs2[31];
        rs1_mag_s    = mag32(rs1, rs1_is_signed(op_in));
        rs2_mag_s    = mag32(rs2, rs2_is_signed(op_in));
        operand_zero = (rs1_mag_s == 32'd0) || (rs2_mag_s == 32'd0);
    end

    // Next-state for operand latch, product shift-add and counter.
    always_comb begin
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        op_d      = op_q;
        product_d = product_q;
        count_d   = count_q;
        hi_sum_s  = {1'b0, product_q[63:32]};
        if (load) begin
            mcand_d   = rs1_mag_s;
            neg_d     = rs1_neg_s ^ rs2_neg_s;
            op_d      = op_in;
            product_d = {32'd0, rs2_mag_s};
            count_d   = {CNT_W{1'b0}};
        end else if (step) begin
            // The low half of the product holds the not-yet-consumed
            // multiplier bits; bit 0 decides whether to add this round.
            if (product_q[0]) begin
                hi_sum_s = {1'b0, product_q[63:32]} + {1'b0, mcand_q};
            end else begin
                hi_sum_s = {1'b0, product_q[63:32]};
            end
            product_d = {hi_sum_s, product_q[31:1]};
            count_d   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            product_d = product_q;
        end
    end

    // Final iteration flag for the FSM.
    always_comb begin
        last_iter = (count_q == CNT_W'(MUL_ITERS - 1));
    end

    // Result register: built from the product as it will be after the
    // final step, so it is valid in the same cycle done rises.
    always_comb begin
        fixed_s  = sign_fix64(product_d, neg_q);
        result_d = result_q;
        if (res_zero) begin
            result_d = 32'd0;
        end else if (res_final) begin
            // The low word is identical for signed and unsigned operands.
            if (op_q == FUNCT3_MUL) begin
                result_d = product_d[31:0];
            end else begin
                result_d = fixed_s[63:32];
            end
        end else begin
            result_d = result_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= 32'd0;
            neg_q     <= 1'b0;
            op_q      <= FUNCT3_MUL;
            product_q <= 64'd0;
            count_q   <= {CNT_W{1'b0}};
            result_q  <= 32'd0;
        end else begin
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            op_q      <= op_d;
            product_q <= product_d;
            count_q   <= count_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/multiplier_unit.sv
// Sequential radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Control FSM and handshake; arithmetic lives in multiplier_datapath.
module multiplier_unit
    import multiplier_unit_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  mult_funct3_t mult_op,
    input  logic [31:0]  multiplicand,
    input  logic [31:0]  multiplier,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [31:0]  result
);

    mul_state_t state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       load_s;
    logic       step_s;
    logic       res_final_s;
    logic       res_zero_s;
    logic       operand_zero_s;
    logic       last_iter_s;

    multiplier_datapath u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load_s),
        .op_in        (mult_op),
        .rs1          (multiplicand),
        .rs2          (multiplier),
        .step         (step_s),
        .res_final    (res_final_s),
        .res_zero     (res_zero_s),
        .operand_zero (operand_zero_s),
        .last_iter    (last_iter_s),
        .result       (result)
    );

    // FSM next state and datapath control; flush always returns to IDLE.
    always_comb begin
        state_d     = state_q;
        load_s      = 1'b0;
        step_s      = 1'b0;
        res_final_s = 1'b0;
        res_zero_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (start && is_mul_op(mult_op)) begin
                    load_s = 1'b1;
                    if (ZERO_BYPASS && operand_zero_s) begin
                        state_d    = ST_DONE;
                        res_zero_s = 1'b1;
                    end else begin
                        state_d = ST_COMPUTE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (last_iter_s) begin
                        state_d     = ST_DONE;
                        res_final_s = 1'b1;
                    end else begin
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule
